// File: rtl/dm_port_arbiter.sv
// Two-master arbiter in front of the word-wide data memory: round-robin with
// capped locked bursts, byte-lane store merging and registered load responses.
module dm_port_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m0_pc,
  output logic        m0_gnt,
  output logic [31:0] m0_rdata,
  output logic        m0_rvalid,

  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [31:0] m1_pc,
  output logic        m1_gnt,
  output logic [31:0] m1_rdata,
  output logic        m1_rvalid,

  output logic        dm_we,
  output logic [31:0] dm_a,
  output logic [31:0] dm_wd,
  input  logic [31:0] dm_rd,
  output logic [31:0] dm_pc
);

  // Handshake: a master holds mN_req (and its command fields) stable until it
  // sees mN_gnt; the access is performed in the cycle mN_gnt is high. Loads
  // return mN_rdata with a one-cycle mN_rvalid pulse on the following cycle.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } own_t;

  localparam logic [CNT_W-1:0] CAP = CNT_W'(MAX_BURST);

  own_t             own_q, own_d;
  logic             rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             g0, g1, any_gnt, cont, rr_eff, below_cap;
  logic             sel_lock, sel_we;
  logic [3:0]       sel_be;
  logic [31:0]      sel_addr, sel_wdata, sel_pc, wd_merge;
  logic             store;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{m0_addr[1:0], m1_addr[1:0]};
  assign below_cap = (cnt_q < CAP);

  // Owner continuation first; a displaced owner hands preference to the other side.
  always_comb begin
    g0     = 1'b0;
    g1     = 1'b0;
    cont   = 1'b0;
    rr_eff = rr_q;
    if (!reset) begin
      if (own_q == OWN0 && m0_req && below_cap) begin
        g0   = 1'b1;
        cont = 1'b1;
      end else if (own_q == OWN1 && m1_req && below_cap) begin
        g1   = 1'b1;
        cont = 1'b1;
      end else begin
        if (own_q == OWN0)      rr_eff = 1'b1;
        else if (own_q == OWN1) rr_eff = 1'b0;
        if (m0_req && m1_req) begin
          g0 = ~rr_eff;
          g1 = rr_eff;
        end else begin
          g0 = m0_req;
          g1 = m1_req;
        end
      end
    end
  end

  assign m0_gnt  = g0;
  assign m1_gnt  = g1;
  assign any_gnt = g0 | g1;

  always_comb begin
    sel_lock  = 1'b0;
    sel_we    = 1'b0;
    sel_be    = 4'b0000;
    sel_addr  = 32'h0;
    sel_wdata = 32'h0;
    sel_pc    = 32'h0;
    if (g0) begin
      sel_lock  = m0_lock;
      sel_we    = m0_we;
      sel_be    = m0_be;
      sel_addr  = m0_addr;
      sel_wdata = m0_wdata;
      sel_pc    = m0_pc;
    end else if (g1) begin
      sel_lock  = m1_lock;
      sel_we    = m1_we;
      sel_be    = m1_be;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
      sel_pc    = m1_pc;
    end
  end

  // Unselected byte lanes keep the memory's current contents.
  always_comb begin
    wd_merge = 32'h0;
    for (int i = 0; i < 4; i++) begin
      wd_merge[8*i +: 8] = sel_be[i] ? sel_wdata[8*i +: 8] : dm_rd[8*i +: 8];
    end
  end

  assign store = any_gnt & sel_we;
  assign dm_we = store & (|sel_be);
  assign dm_a  = any_gnt ? {sel_addr[31:2], 2'b00} : 32'h0;
  assign dm_wd = store ? wd_merge : 32'h0;
  assign dm_pc = any_gnt ? sel_pc : 32'h0;

  always_comb begin
    own_d = IDLE;
    cnt_d = '0;
    rr_d  = rr_eff;
    if (any_gnt && sel_lock) begin
      own_d = g0 ? OWN0 : OWN1;
      cnt_d = cont ? cnt_q + CNT_W'(1) : CNT_W'(1);
    end else if (any_gnt) begin
      rr_d = g0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      own_q <= IDLE;
      rr_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      own_q <= own_d;
      rr_q  <= rr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m0_rvalid <= 1'b0;
      m0_rdata  <= 32'h0;
      m1_rvalid <= 1'b0;
      m1_rdata  <= 32'h0;
    end else begin
      m0_rvalid <= g0 & ~m0_we;
      m1_rvalid <= g1 & ~m1_we;
      if (g0 && !m0_we) m0_rdata <= dm_rd;
      if (g1 && !m1_we) m1_rdata <= dm_rd;
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a small behavioural data memory
// attached to the dm_* side; expected values are hand-derived constants.
module tb_dm_port_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_lock, m0_we;
  logic [3:0]  m0_be;
  logic [31:0] m0_addr, m0_wdata, m0_pc, m0_rdata;
  logic        m0_gnt, m0_rvalid;
  logic        m1_req, m1_lock, m1_we;
  logic [3:0]  m1_be;
  logic [31:0] m1_addr, m1_wdata, m1_pc, m1_rdata;
  logic        m1_gnt, m1_rvalid;
  logic        dm_we;
  logic [31:0] dm_a, dm_wd, dm_rd, dm_pc;

  logic [31:0] mem [0:63];
  logic        pre_we;
  logic [5:0]  pre_idx;
  logic [31:0] pre_d;

  int checks   = 0;
  int failures = 0;

  dm_port_arbiter #(.MAX_BURST(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we), .m0_be(m0_be),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_pc(m0_pc),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we), .m1_be(m1_be),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_pc(m1_pc),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .dm_we(dm_we), .dm_a(dm_a), .dm_wd(dm_wd), .dm_rd(dm_rd), .dm_pc(dm_pc)
  );

  // Clock and memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dm_rd = mem[dm_a[7:2]];
  always @(posedge clk) begin
    if (pre_we)     mem[pre_idx] <= pre_d;
    else if (dm_we) mem[dm_a[7:2]] <= dm_wd;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_m0(input logic req, input logic lock, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] pc);
    m0_req = req; m0_lock = lock; m0_we = we; m0_be = be;
    m0_addr = addr; m0_wdata = wdata; m0_pc = pc;
  endtask

  task automatic set_m1(input logic req, input logic lock, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] pc);
    m1_req = req; m1_lock = lock; m1_we = we; m1_be = be;
    m1_addr = addr; m1_wdata = wdata; m1_pc = pc;
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] d);
    pre_we = 1'b1; pre_idx = idx; pre_d = d;
    tick();
    pre_we = 1'b0;
  endtask

  // Scoreboard comparisons
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  bit [7:0] exp2_g0 = 8'b0110_1111;
  bit [8:0] cap_g1  = 9'b0_1111_1111;

  initial begin
    int m0_beats;
    logic eg0, eg1, m0r;
    reset = 1'b1;
    pre_we = 1'b0; pre_idx = '0; pre_d = '0;
    set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
    set_m1(0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);

    preload(6'd0,  32'hAAAA0000);
    preload(6'd1,  32'hBBBB1111);
    preload(6'd4,  32'h11223344);
    preload(6'd8,  32'h00000000);
    preload(6'd12, 32'h55555555);

    // Reset: requests present, nothing granted or written
    set_m0(1, 0, 1, 4'hF, 32'h0, 32'hDEADBEEF, 32'h0);
    set_m1(1, 0, 0, 4'h0, 32'h4, 32'h0, 32'h0);
    settle();
    chk1("rst_g0", m0_gnt, 1'b0);
    chk1("rst_g1", m1_gnt, 1'b0);
    chk1("rst_dm_we", dm_we, 1'b0);
    tick();
    chk1("rst_rv0", m0_rvalid, 1'b0);
    chk1("rst_rv1", m1_rvalid, 1'b0);
    chk("rst_rd0", m0_rdata, 32'h0);
    chk("rst_rd1", m1_rdata, 32'h0);

    // Both loads held, no lock: strict alternation starting with m0
    reset = 1'b0;
    set_m0(1, 0, 0, 4'h0, 32'h0, 32'h0, 32'h100);
    set_m1(1, 0, 0, 4'h0, 32'h4, 32'h0, 32'h200);
    for (int i = 0; i < 4; i++) begin
      eg1 = (i % 2) == 1;
      settle();
      chk1($sformatf("t1_g0_c%0d", i), m0_gnt, !eg1);
      chk1($sformatf("t1_g1_c%0d", i), m1_gnt, eg1);
      chk($sformatf("t1_dm_a_c%0d", i), dm_a, eg1 ? 32'h4 : 32'h0);
      chk($sformatf("t1_dm_pc_c%0d", i), dm_pc, eg1 ? 32'h200 : 32'h100);
      tick();
      chk1($sformatf("t1_rv0_c%0d", i), m0_rvalid, !eg1);
      chk1($sformatf("t1_rv1_c%0d", i), m1_rvalid, eg1);
      if (eg1) chk($sformatf("t1_rd1_c%0d", i), m1_rdata, 32'hBBBB1111);
      else     chk($sformatf("t1_rd0_c%0d", i), m0_rdata, 32'hAAAA0000);
    end
    set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
    set_m1(0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
    settle();
    chk1("idle_g0", m0_gnt, 1'b0);
    chk1("idle_g1", m1_gnt, 1'b0);
    chk("idle_dm_a", dm_a, 32'h0);
    chk("idle_dm_pc", dm_pc, 32'h0);
    tick();
    chk1("idle_rv0", m0_rvalid, 1'b0);
    chk("idle_rd0_hold", m0_rdata, 32'hAAAA0000);

    // m0 six-beat locked burst against a persistent m1: 4 / 1 / 2
    m0_beats = 0;
    for (int i = 0; i < 8; i++) begin
      m0r = m0_beats < 6;
      set_m0(m0r, m0_beats < 5, 0, 4'h0, 32'h0, 32'h0, 32'h100);
      set_m1(1, 0, 0, 4'h0, 32'h4, 32'h0, 32'h200);
      eg0 = exp2_g0[i];
      settle();
      chk1($sformatf("t2_g0_c%0d", i), m0_gnt, eg0);
      chk1($sformatf("t2_g1_c%0d", i), m1_gnt, !eg0);
      if (eg0) m0_beats++;
      tick();
    end
    set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
    set_m1(0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
    tick();

    // Partial store from m1 merges into the existing word
    set_m1(1, 0, 1, 4'b0010, 32'h12, 32'h0000AB00, 32'h1234);
    settle();
    chk1("t3_g1", m1_gnt, 1'b1);
    chk1("t3_dm_we", dm_we, 1'b1);
    chk("t3_dm_a", dm_a, 32'h10);
    chk("t3_dm_wd", dm_wd, 32'h1122AB44);
    chk("t3_dm_pc", dm_pc, 32'h1234);
    tick();
    chk("t3_mem", mem[4], 32'h1122AB44);
    chk1("t3_rv1", m1_rvalid, 1'b0);
    set_m1(0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);

    // Store with no byte enables: granted, memory untouched
    set_m0(1, 0, 1, 4'b0000, 32'h10, 32'hFFFFFFFF, 32'h40);
    settle();
    chk1("t5_g0", m0_gnt, 1'b1);
    chk1("t5_dm_we", dm_we, 1'b0);
    chk("t5_dm_pc", dm_pc, 32'h40);
    tick();
    chk("t5_mem", mem[4], 32'h1122AB44);
    chk1("t5_rv0", m0_rvalid, 1'b0);

    // Full-word store, then read back the merged word
    set_m0(1, 0, 1, 4'b1111, 32'h20, 32'hCAFEF00D, 32'h44);
    settle();
    chk("fw_dm_wd", dm_wd, 32'hCAFEF00D);
    chk("fw_dm_a", dm_a, 32'h20);
    tick();
    chk("fw_mem", mem[8], 32'hCAFEF00D);
    set_m0(1, 0, 0, 4'h0, 32'h10, 32'h0, 32'h48);
    tick();
    chk1("rb_rv0", m0_rvalid, 1'b1);
    chk("rb_rd0", m0_rdata, 32'h1122AB44);
    set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);

    // Lone locked m1 hits the cap, restarts a burst, then yields to m0
    for (int i = 0; i < 9; i++) begin
      m0r = i >= 5;
      set_m1(1, 1, 0, 4'h0, 32'h4, 32'h0, 32'h200);
      set_m0(m0r, 0, 0, 4'h0, 32'h0, 32'h0, 32'h100);
      eg1 = cap_g1[i];
      settle();
      chk1($sformatf("cap_g1_c%0d", i), m1_gnt, eg1);
      chk1($sformatf("cap_g0_c%0d", i), m0_gnt, m0r && !eg1);
      tick();
    end
    set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
    set_m1(0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
    tick();

    // Reset on the 2nd beat of an m1 locked burst
    set_m1(1, 1, 0, 4'h0, 32'h4, 32'h0, 32'h200);
    settle();
    chk1("t4_b1_g1", m1_gnt, 1'b1);
    tick();
    chk1("t4_b1_rv1", m1_rvalid, 1'b1);
    chk("t4_b1_rd1", m1_rdata, 32'hBBBB1111);
    reset = 1'b1;
    set_m1(1, 1, 1, 4'hF, 32'h30, 32'h66666666, 32'h204);
    settle();
    chk1("t4_rst_g1", m1_gnt, 1'b0);
    chk1("t4_rst_g0", m0_gnt, 1'b0);
    chk1("t4_rst_dm_we", dm_we, 1'b0);
    tick();
    chk("t4_rst_mem", mem[12], 32'h55555555);
    chk1("t4_rst_rv1", m1_rvalid, 1'b0);
    reset = 1'b0;
    set_m0(1, 0, 0, 4'h0, 32'h0, 32'h0, 32'h100);
    set_m1(1, 0, 0, 4'h0, 32'h4, 32'h0, 32'h200);
    settle();
    chk1("t4_post_g0", m0_gnt, 1'b1);
    chk1("t4_post_g1", m1_gnt, 1'b0);
    tick();
    chk1("t4_post_rv0", m0_rvalid, 1'b1);
    chk("t4_post_rd0", m0_rdata, 32'hAAAA0000);
    set_m0(0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
    set_m1(0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0);
    tick();

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
